// File: rtl/serial_add_driver.sv
// Parallel-side controller for the bit-serial adder: shifts operands out LSB-first and collects the serial sum.
// Optional carry-out collection is enabled with `define SERIAL_ADD_DRIVER_COUT_EN.
module serial_add_driver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned S_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             s_ser,
    output logic             a_ser,
    output logic             b_ser,
    output logic             ser_en,
    output logic             ser_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

`ifdef SERIAL_ADD_DRIVER_COUT_EN
    localparam int unsigned N = WIDTH + 1;
`else
    localparam int unsigned N = WIDTH;
`endif
    localparam int unsigned CW = $clog2(N + S_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t          state;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-2:0]    s_sh;
    logic [CW-1:0]   cnt;
    logic            sample;
    logic            fin;
    logic [N-1:0]    s_nxt;

    // Sum bits lag the operand bits by S_LAT cycles, so sampling starts S_LAT cycles into SHIFT.
    generate
        if (S_LAT == 0) begin : g_comb_sum
            assign sample = (state == SHIFT);
            assign fin    = (state == SHIFT) && (cnt == CW'(N - 1));
        end else begin : g_reg_sum
            assign sample = ((state == SHIFT) && (cnt >= CW'(S_LAT))) || (state == DRAIN);
            assign fin    = (state == DRAIN) && (cnt == CW'(S_LAT - 1));
        end
    endgenerate

    assign s_nxt   = {s_ser, s_sh};
    assign ser_rst = rst | (state == CLR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_ser   <= 1'b0;
            b_ser   <= 1'b0;
            ser_en  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            sum_out <= '0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
        end else begin
            done <= 1'b0;
            if (sample) begin
                s_sh <= s_nxt[N-1:1];
            end
            if (fin) begin
                sum_out <= s_nxt[WIDTH-1:0];
                done    <= 1'b1;
                state   <= DONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= N'(a_in);
                        b_sh  <= N'(b_in);
                        s_sh  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CLR;
                    end
                end
                CLR: begin
                    a_ser  <= a_sh[0];
                    b_ser  <= b_sh[0];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    ser_en <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CW'(N - 1)) begin
                        a_ser  <= 1'b0;
                        b_ser  <= 1'b0;
                        ser_en <= 1'b0;
                        cnt    <= '0;
                        if (S_LAT != 0) begin
                            state <= DRAIN;
                        end
                    end else begin
                        a_ser <= a_sh[0];
                        b_ser <= b_sh[0];
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_DRIVER_COUT_EN
    // The final sampled bit is the adder's carry out of the top operand bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout <= 1'b0;
        end else if (fin) begin
            cout <= s_nxt[N-1];
        end
    end
`else
    assign cout = 1'b0;
`endif

endmodule
